pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_stack_unit.sv | 120 ++++++++++++
 tb/tb_pc_stack_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program-counter sequencer with a hardware return-address stack.
// Handles sequential/relative/absolute/return flow, calls, co-routine swaps and sticky stack errors.
module pc_stack_unit #(
  parameter int unsigned     PC_W     = 12,
  parameter int unsigned     OFF_W    = 8,
  parameter int unsigned     DEPTH    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [1:0]                   pc_sel,
  input  logic [OFF_W-1:0]             offset,
  input  logic [PC_W-1:0]              target,
  input  logic                         push,
  input  logic                         err_clr,
  output logic [PC_W-1:0]              pc,
  output logic [PC_W-1:0]              pc_plus1,
  output logic [PC_W-1:0]              ret_addr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         ovf_err,
  output logic                         unf_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_REL = 2'b01,
    SEL_ABS = 2'b10,
    SEL_RET = 2'b11
  } sel_e;

  logic [PC_W-1:0] stack [DEPTH];
  logic [IW-1:0]   top_idx;
  logic [IW-1:0]   wr_idx;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] next_pc;
  logic [CW-1:0]   next_count;
  logic            stk_we;
  logic            ovf_ev;
  logic            unf_ev;
  sel_e            sel;

  assign sel      = sel_e'(pc_sel);
  assign pc_plus1 = pc + PC_W'(1);
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  // Index is only meaningful when non-empty; the wrapped value on empty is masked below.
  assign top_idx  = IW'(count - CW'(1));
  assign ret_addr = empty ? '0 : stack[top_idx];
  assign off_ext  = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};

  always_comb begin
    next_pc = pc_plus1;
    unique case (sel)
      SEL_SEQ: next_pc = pc_plus1;
      SEL_REL: next_pc = pc_plus1 + off_ext;
      SEL_ABS: next_pc = target;
      SEL_RET: next_pc = empty ? pc_plus1 : ret_addr;
    endcase
  end

  always_comb begin
    next_count = count;
    stk_we     = 1'b0;
    wr_idx     = IW'(count);
    ovf_ev     = 1'b0;
    unf_ev     = 1'b0;
    if (sel == SEL_RET) begin
      if (empty) begin
        unf_ev = 1'b1;
        if (push) begin
          stk_we     = 1'b1;
          wr_idx     = '0;
          next_count = CW'(1);
        end
      end else if (push) begin
        // Co-routine swap: pop and push collapse into an overwrite of the top entry.
        stk_we = 1'b1;
        wr_idx = top_idx;
      end else begin
        next_count = count - CW'(1);
      end
    end else if (push) begin
      if (full) begin
        ovf_ev = 1'b1;
      end else begin
        stk_we     = 1'b1;
        wr_idx     = IW'(count);
        next_count = count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc      <= RESET_PC;
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (!stall) begin
      pc      <= next_pc;
      count   <= next_count;
      ovf_err <= ovf_ev | (ovf_err & ~err_clr);
      unf_err <= unf_ev | (unf_err & ~err_clr);
    end
  end

  // Stack storage is never cleared; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (reset && !stall && stk_we) begin
      stack[wr_idx] <= pc_plus1;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed vector table, a deep-stack sequence,
// and randomized traffic scored against a queue-based reference model.
module tb_pc_stack_unit;

  localparam int unsigned PC_W  = 12;
  localparam int unsigned OFF_W = 8;
  localparam int unsigned DEPTH = 8;
  localparam int          MASK  = (1 << PC_W) - 1;

  logic             clk;
  logic             reset;
  logic             stall;
  logic [1:0]       pc_sel;
  logic [OFF_W-1:0] offset;
  logic [PC_W-1:0]  target;
  logic             push;
  logic             err_clr;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_plus1;
  logic [PC_W-1:0]  ret_addr;
  logic [3:0]       count;
  logic             empty;
  logic             full;
  logic             ovf_err;
  logic             unf_err;

  int tests  = 0;
  int failed = 0;

  pc_stack_unit #(
    .PC_W    (PC_W),
    .OFF_W   (OFF_W),
    .DEPTH   (DEPTH),
    .RESET_PC(12'h000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .pc_sel  (pc_sel),
    .offset  (offset),
    .target  (target),
    .push    (push),
    .err_clr (err_clr),
    .pc      (pc),
    .pc_plus1(pc_plus1),
    .ret_addr(ret_addr),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .ovf_err (ovf_err),
    .unf_err (unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        rst_n;
    bit        stl;
    bit [1:0]  sel;
    bit [7:0]  off;
    bit [11:0] tgt;
    bit        psh;
    bit        clr;
    int        e_pc;
    int        e_cnt;
    int        e_ret;
    bit        e_ovf;
    bit        e_unf;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  int          m_pc;
  logic [11:0] m_stk[$];
  bit          m_ovf;
  bit          m_unf;

  function automatic vec_t mk(bit r, bit s, bit [1:0] sl, bit [7:0] o, bit [11:0] t, bit p, bit c,
                              int epc, int ecnt, int eret, bit eovf, bit eunf);
    vec_t v;
    v.rst_n = r; v.stl = s; v.sel = sl; v.off = o; v.tgt = t; v.psh = p; v.clr = c;
    v.e_pc = epc; v.e_cnt = ecnt; v.e_ret = eret; v.e_ovf = eovf; v.e_unf = eunf;
    return v;
  endfunction

  task automatic drive(input bit r, input bit s, input bit [1:0] sl, input bit [7:0] o,
                       input bit [11:0] t, input bit p, input bit c);
    reset = r; stall = s; pc_sel = sl; offset = o; target = t; push = p; err_clr = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int epc, input int ecnt, input int eret,
                           input bit eovf, input bit eunf);
    chk({tag, ".pc"},       int'(pc),       epc);
    chk({tag, ".pc_plus1"}, int'(pc_plus1), (epc + 1) & MASK);
    chk({tag, ".count"},    int'(count),    ecnt);
    chk({tag, ".ret_addr"}, int'(ret_addr), eret);
    chk({tag, ".empty"},    int'(empty),    int'(ecnt == 0));
    chk({tag, ".full"},     int'(full),     int'(ecnt == int'(DEPTH)));
    chk({tag, ".ovf_err"},  int'(ovf_err),  int'(eovf));
    chk({tag, ".unf_err"},  int'(unf_err),  int'(eunf));
  endtask

  // Behavioural model: applies one clock edge worth of architectural rules.
  task automatic model_step(input bit r, input bit s, input bit [1:0] sl, input bit [7:0] o,
                            input bit [11:0] t, input bit p, input bit c);
    int  plus1;
    int  np;
    bit  was_empty;
    bit  ovf_ev;
    bit  unf_ev;
    if (!r) begin
      m_pc  = 0;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (!s) begin
      plus1     = (m_pc + 1) & MASK;
      was_empty = (m_stk.size() == 0);
      ovf_ev    = 0;
      unf_ev    = 0;
      case (sl)
        2'd0: np = plus1;
        2'd1: np = (plus1 + int'($signed(o))) & MASK;
        2'd2: np = int'(t);
        default: np = was_empty ? plus1 : int'(m_stk[$]);
      endcase
      if (sl == 2'd3) begin
        if (was_empty) begin
          unf_ev = 1;
          if (p) m_stk.push_back(12'(plus1));
        end else if (p) begin
          m_stk[m_stk.size()-1] = 12'(plus1);
        end else begin
          void'(m_stk.pop_back());
        end
      end else if (p) begin
        if (m_stk.size() == int'(DEPTH)) ovf_ev = 1;
        else m_stk.push_back(12'(plus1));
      end
      m_ovf = ovf_ev | (m_ovf & ~c);
      m_unf = unf_ev | (m_unf & ~c);
      m_pc  = np;
    end
  endtask

  initial begin
    int          p;
    int          ret_exp[$];
    bit          r, s, ps, cl;
    bit [1:0]    sl;
    bit [7:0]    o;
    bit [11:0]   t;
    drive(0, 0, 2'd0, 8'h00, 12'h000, 0, 0);

    // Directed vector table (starts from reset)
    tbl.push_back(mk(0,0,2'd0,8'h00,12'h000,0,0, 12'h000,0,12'h000,0,0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(1,0,2'd0,8'h00,12'h000,0,0, i,0,0,0,0));
    tbl.push_back(mk(1,0,2'd2,8'h00,12'h010,0,0, 12'h010,0,12'h000,0,0));
    tbl.push_back(mk(1,0,2'd1,8'hFE,12'h000,0,0, 12'h00F,0,12'h000,0,0));
    tbl.push_back(mk(1,0,2'd2,8'h00,12'h010,0,0, 12'h010,0,12'h000,0,0));
    tbl.push_back(mk(1,0,2'd1,8'h05,12'h000,0,0, 12'h016,0,12'h000,0,0));
    tbl.push_back(mk(1,0,2'd2,8'h00,12'h020,0,0, 12'h020,0,12'h000,0,0));
    tbl.push_back(mk(1,0,2'd2,8'h00,12'h100,1,0, 12'h100,1,12'h021,0,0));
    tbl.push_back(mk(1,0,2'd3,8'h00,12'h000,0,0, 12'h021,0,12'h000,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,1,2'd2,8'h00,12'h300,1,0, 12'h021,0,12'h000,0,0));
    tbl.push_back(mk(1,0,2'd2,8'h00,12'h300,1,0, 12'h300,1,12'h022,0,0));
    tbl.push_back(mk(1,0,2'd0,8'h00,12'h000,0,0, 12'h301,1,12'h022,0,0));
    tbl.push_back(mk(1,0,2'd2,8'h00,12'h04F,0,0, 12'h04F,1,12'h022,0,0));
    tbl.push_back(mk(1,0,2'd2,8'h00,12'h200,1,0, 12'h200,2,12'h050,0,0));
    tbl.push_back(mk(1,0,2'd3,8'h00,12'h000,1,0, 12'h050,2,12'h201,0,0));
    tbl.push_back(mk(0,1,2'd2,8'h00,12'h003,1,0, 12'h000,0,12'h000,0,0));
    tbl.push_back(mk(1,0,2'd2,8'h00,12'hFFF,0,0, 12'hFFF,0,12'h000,0,0));
    tbl.push_back(mk(1,0,2'd0,8'h00,12'h000,0,0, 12'h000,0,12'h000,0,0));
    tbl.push_back(mk(1,0,2'd1,8'h80,12'h000,0,0, 12'hF81,0,12'h000,0,0));
    tbl.push_back(mk(1,0,2'd3,8'h00,12'h000,0,0, 12'hF82,0,12'h000,0,1));
    tbl.push_back(mk(1,1,2'd0,8'h00,12'h000,0,1, 12'hF82,0,12'h000,0,1));
    tbl.push_back(mk(1,0,2'd0,8'h00,12'h000,0,1, 12'hF83,0,12'h000,0,0));
    tbl.push_back(mk(1,0,2'd3,8'h00,12'h000,1,1, 12'hF84,1,12'hF84,0,1));
    tbl.push_back(mk(1,0,2'd0,8'h00,12'h000,0,1, 12'hF85,1,12'hF84,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].stl, tbl[i].sel, tbl[i].off, tbl[i].tgt, tbl[i].psh, tbl[i].clr);
      step();
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_cnt, tbl[i].e_ret,
                tbl[i].e_ovf, tbl[i].e_unf);
    end

    // Deep-stack sequence: overflow on the 9th call, LIFO unwind, underflow, clear
    drive(0, 0, 2'd0, 8'h00, 12'h000, 0, 0);
    step();
    p = 0;
    for (int i = 0; i < 9; i++) begin
      t = 12'(12'h100 + i * 16);
      drive(1, 0, 2'd2, 8'h00, t, 1, 0);
      step();
      if (i < 8) ret_exp.push_back((p + 1) & MASK);
      p = int'(t);
      check_all($sformatf("call%0d", i), p, ret_exp.size(), ret_exp[$], i == 8, 0);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 2'd3, 8'h00, 12'h000, 0, 0);
      step();
      p = ret_exp.pop_back();
      check_all($sformatf("ret%0d", i), p, ret_exp.size(),
                ret_exp.size() > 0 ? ret_exp[$] : 0, 1, 0);
    end
    drive(1, 0, 2'd3, 8'h00, 12'h000, 0, 0);
    step();
    p = (p + 1) & MASK;
    check_all("ret_empty", p, 0, 0, 1, 1);
    drive(1, 0, 2'd0, 8'h00, 12'h000, 0, 1);
    step();
    p = (p + 1) & MASK;
    check_all("err_clr", p, 0, 0, 0, 0);

    // Randomized traffic against the reference model
    drive(0, 0, 2'd0, 8'h00, 12'h000, 0, 0);
    model_step(0, 0, 2'd0, 8'h00, 12'h000, 0, 0);
    step();
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(63) != 0);
      s  = ($urandom_range(3) == 0);
      sl = 2'($urandom_range(3));
      o  = 8'($urandom);
      t  = 12'($urandom);
      ps = ($urandom_range(2) == 0);
      cl = ($urandom_range(7) == 0);
      drive(r, s, sl, o, t, ps, cl);
      model_step(r, s, sl, o, t, ps, cl);
      step();
      check_all($sformatf("rnd%0d", n), m_pc, m_stk.size(),
                m_stk.size() > 0 ? int'(m_stk[$]) : 0, m_ovf, m_unf);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
